// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall masks, stall bit indices, state encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Stall vector bit positions, one per pipeline register (PC first).
  localparam int StallBitPc  = 0;
  localparam int StallBitIf  = 1;
  localparam int StallBitId  = 2;
  localparam int StallBitEx  = 3;
  localparam int StallBitMem = 4;
  localparam int StallBitWb  = 5;

  // A stalling stage freezes itself and every stage upstream of it.
  localparam logic [5:0] NoStall = 6'b000000;
  localparam logic [5:0] StallIf = 6'b000011;
  localparam logic [5:0] StallId = 6'b000111;
  localparam logic [5:0] StallEx = 6'b001111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MC_RUN = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Loadable down-counter with clear, enable and zero/one flags for multi-cycle EX ops.
// Latency: count updates one cycle after load/enable; flags are combinational on the count.
// Backpressure: none; clear beats load, load beats enable, counting stops at zero.
module mc_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         one
);

  // Count register: clear, then load, then decrement while non-zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, holds EX for multi-cycle ops, times flushes (stats: PIPE_CTRL_STATS_EN).
// Latency: stall_o/flush_o/mc_last_o respond combinationally in the request cycle; state advances next edge.
// Backpressure: flush overrides everything; multi-cycle op stalls PC..EX until its last cycle.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_W   = 6,
  parameter int CNT_W     = 6,
  parameter int FLUSH_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               mc_start,
  input  logic [CNT_W-1:0]   mc_len,
  input  logic               flush_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic               mc_busy_o,
  output logic               mc_last_o,
  output logic [CNT_W-1:0]   mc_cnt_o,
  output logic [31:0]        stall_cnt_o
);

  state_t     state, state_nxt;
  logic [1:0] timer, timer_nxt;

  logic             cnt_load, cnt_en, cnt_clr;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero, cnt_one;

  logic mc_long;   // op needs at least one stall cycle
  logic ex_stall;

  mc_counter #(.W(CNT_W)) u_mc_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (mc_len - CNT_W'(1)),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .cnt      (cnt),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  assign mc_long = (mc_len >= CNT_W'(2));

  // State and flush timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= 2'd0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next-state, counter control and status outputs; a flush request wins over everything.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    mc_last_o = 1'b0;
    if (flush_i) begin
      state_nxt = FLUSH;
      timer_nxt = 2'(FLUSH_CYC - 1);
      cnt_clr   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (mc_start && mc_long) begin
            state_nxt = MC_RUN;
            cnt_load  = 1'b1;
          end else if (mc_start) begin
            // Zero/one-cycle ops finish in place without touching the pipeline.
            mc_last_o = 1'b1;
          end
        end
        MC_RUN: begin
          cnt_en = 1'b1;
          if (cnt_one || cnt_zero) begin
            mc_last_o = cnt_one;
            state_nxt = IDLE;
          end
        end
        FLUSH: begin
          if (timer == 2'd0) begin
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer - 2'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign flush_o   = flush_i || (state == FLUSH);
  assign mc_busy_o = (state == MC_RUN) && !flush_i;
  assign mc_cnt_o  = (state == MC_RUN) ? cnt : '0;

  assign ex_stall = stallreq_ex
                 || ((state == MC_RUN) && !cnt_zero && !cnt_one)
                 || ((state == IDLE) && mc_start && mc_long);

  // Stall merge: highest-priority active source selects the mask.
  always_comb begin
    stall_o = STALL_W'(NoStall);
    if (flush_o) begin
      stall_o = STALL_W'(NoStall);
    end else if (ex_stall) begin
      stall_o = STALL_W'(StallEx);
    end else if (stallreq_id) begin
      stall_o = STALL_W'(StallId);
    end else if (stallreq_if) begin
      stall_o = STALL_W'(StallIf);
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt;

  // Saturating count of cycles in which any stage was stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
    end else if ((stall_o != '0) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall merge, multi-cycle sequencing, flush, reset, stall counter.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex;
  logic        mc_start;
  logic [5:0]  mc_len;
  logic        flush_i;
  logic [5:0]  stall_o;
  logic        flush_o, mc_busy_o, mc_last_o;
  logic [5:0]  mc_cnt_o;
  logic [31:0] stall_cnt_o;

  int n_cmp;
  int n_bad;

  pipe_ctrl #(.STALL_W(6), .CNT_W(6), .FLUSH_CYC(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .mc_start    (mc_start),
    .mc_len      (mc_len),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .mc_busy_o   (mc_busy_o),
    .mc_last_o   (mc_last_o),
    .mc_cnt_o    (mc_cnt_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr_in();
    stallreq_if = 1'b0;
    stallreq_id = 1'b0;
    stallreq_ex = 1'b0;
    mc_start    = 1'b0;
    mc_len      = 6'd0;
    flush_i     = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clr_in();
    rst = 1'b0;
    #3;
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_busy", 32'(mc_busy_o), 32'h0);
    chk("rst_last", 32'(mc_last_o), 32'h0);
    chk("rst_cnt", 32'(mc_cnt_o), 32'h0);
    chk("rst_scnt", stall_cnt_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      sample();
      chk("idle_stall", 32'(stall_o), 32'h0);
      chk("idle_flush", 32'(flush_o), 32'h0);
      chk("idle_cnt", 32'(mc_cnt_o), 32'h0);
    end

    // Stall priority: id beats if; ex beats both; flush beats ex.
    next_cyc(); stallreq_if = 1'b1; stallreq_id = 1'b1;
    sample();   chk("if_id", 32'(stall_o), 32'h07);
    next_cyc(); stallreq_id = 1'b0;
    sample();   chk("if_only", 32'(stall_o), 32'h03);
    next_cyc(); stallreq_if = 1'b0; stallreq_ex = 1'b1; flush_i = 1'b1;
    sample();   chk("ex_flush_stall", 32'(stall_o), 32'h00);
                chk("ex_flush_fo", 32'(flush_o), 32'h1);
    next_cyc(); flush_i = 1'b0;
    sample();   chk("flushst_stall", 32'(stall_o), 32'h00);
                chk("flushst_fo", 32'(flush_o), 32'h1);
    next_cyc();
    sample();   chk("ex_only", 32'(stall_o), 32'h0F);
                chk("ex_only_fo", 32'(flush_o), 32'h0);
    next_cyc(); clr_in();

    // Multi-cycle op of length 5.
    mc_start = 1'b1; mc_len = 6'd5;
    sample();   chk("mc5_t_stall", 32'(stall_o), 32'h0F);
                chk("mc5_t_last", 32'(mc_last_o), 32'h0);
    next_cyc(); clr_in();
    for (int i = 1; i <= 4; i++) begin
      sample();
      chk("mc5_cnt", 32'(mc_cnt_o), 32'(5 - i));
      chk("mc5_stall", 32'(stall_o), (i < 4) ? 32'h0F : 32'h00);
      chk("mc5_last", 32'(mc_last_o), (i == 4) ? 32'h1 : 32'h0);
      chk("mc5_busy", 32'(mc_busy_o), 32'h1);
      next_cyc();
    end
    sample();   chk("mc5_done_busy", 32'(mc_busy_o), 32'h0);
                chk("mc5_done_cnt", 32'(mc_cnt_o), 32'h0);
                chk("mc5_done_last", 32'(mc_last_o), 32'h0);

    // Length 1 and 0 complete in place.
    next_cyc(); mc_start = 1'b1; mc_len = 6'd1;
    sample();   chk("mc1_last", 32'(mc_last_o), 32'h1);
                chk("mc1_stall", 32'(stall_o), 32'h0);
    next_cyc(); mc_len = 6'd0;
    sample();   chk("mc0_last", 32'(mc_last_o), 32'h1);
                chk("mc0_busy", 32'(mc_busy_o), 32'h0);
    next_cyc(); clr_in();
    sample();   chk("mc1_idle_busy", 32'(mc_busy_o), 32'h0);
                chk("mc1_idle_cnt", 32'(mc_cnt_o), 32'h0);

    // Flush aborts a running op at cnt=3; mc_start during FLUSH is ignored.
    next_cyc(); mc_start = 1'b1; mc_len = 6'd5;
    next_cyc(); clr_in();
    sample();   chk("ab_cnt4", 32'(mc_cnt_o), 32'h4);
    next_cyc(); flush_i = 1'b1;
    sample();   chk("ab_cnt3", 32'(mc_cnt_o), 32'h3);
                chk("ab_fo0", 32'(flush_o), 32'h1);
                chk("ab_stall0", 32'(stall_o), 32'h0);
                chk("ab_last0", 32'(mc_last_o), 32'h0);
    next_cyc(); flush_i = 1'b0; mc_start = 1'b1; mc_len = 6'd5;
    sample();   chk("ab_fo1", 32'(flush_o), 32'h1);
                chk("ab_stall1", 32'(stall_o), 32'h0);
                chk("ab_busy1", 32'(mc_busy_o), 32'h0);
    next_cyc(); clr_in();
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("ab_after_busy", 32'(mc_busy_o), 32'h0);
      chk("ab_after_last", 32'(mc_last_o), 32'h0);
      chk("ab_after_fo", 32'(flush_o), 32'h0);
      chk("ab_after_stall", 32'(stall_o), 32'h0);
      next_cyc();
    end

    // Asynchronous reset in the middle of an op.
    mc_start = 1'b1; mc_len = 6'd8;
    next_cyc(); clr_in();
    #2; rst = 1'b0;
    #1;
    chk("arst_busy", 32'(mc_busy_o), 32'h0);
    chk("arst_cnt", 32'(mc_cnt_o), 32'h0);
    chk("arst_stall", 32'(stall_o), 32'h0);
    chk("arst_scnt", stall_cnt_o, 32'h0);
    next_cyc(); rst = 1'b1;

    // Exactly ten stalled cycles after reset.
    stallreq_id = 1'b1;
    for (int i = 0; i < 10; i++) next_cyc();
    clr_in();
    sample();
`ifdef PIPE_CTRL_STATS_EN
    chk("stall_cnt", stall_cnt_o, 32'd10);
`else
    chk("stall_cnt", stall_cnt_o, 32'd0);
`endif
    chk("end_stall", 32'(stall_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
